// File: rtl/sprite_pkg.sv
// Shared coordinate types and the signed window test used by every sprite channel.
package sprite_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0]  coord_t;
  typedef logic signed [COORD_W:0] scoord_t;

  function automatic logic abs_le(scoord_t d, int lim);
    int v;
    v = int'(d);
    return (v <= lim) && (v >= -lim);
  endfunction

endpackage

// File: rtl/sprite_box_test.sv
// One sprite channel: signed distance from the box centre, inclusive window test and sprite-local offsets.
module sprite_box_test #(
  parameter int COORD_W = 10,
  parameter int HALF_W  = 42,
  parameter int HALF_H  = 46,
  parameter int LX_W    = 7,
  parameter int LY_W    = 7
) (
  input  logic               en_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  output logic               in_o,
  output logic [LX_W-1:0]    off_x_o,
  output logic [LY_W-1:0]    off_y_o
);
  import sprite_pkg::*;

  logic signed [COORD_W:0]   dx;
  logic signed [COORD_W:0]   dy;
  logic signed [COORD_W+1:0] sumX;
  logic signed [COORD_W+1:0] sumY;
  logic                      inX;
  logic                      inY;
  logic                      unused_hi;

  // Zero-extended operands keep a centre near 0 from aliasing onto the far screen edge.
  assign dx = $signed({1'b0, x_i}) - $signed({1'b0, cx_i});
  assign dy = $signed({1'b0, y_i}) - $signed({1'b0, cy_i});

  if (COORD_W == sprite_pkg::COORD_W) begin : g_pkg
    assign inX = abs_le(scoord_t'(dx), HALF_W);
    assign inY = abs_le(scoord_t'(dy), HALF_H);
  end else begin : g_wide
    assign inX = (int'(dx) <= HALF_W) && (int'(dx) >= -HALF_W);
    assign inY = (int'(dy) <= HALF_H) && (int'(dy) >= -HALF_H);
  end

  assign in_o = en_i && inX && inY;

  assign sumX    = (COORD_W+2)'(dx) + (COORD_W+2)'(HALF_W);
  assign sumY    = (COORD_W+2)'(dy) + (COORD_W+2)'(HALF_H);
  assign off_x_o = sumX[LX_W-1:0];
  assign off_y_o = sumY[LY_W-1:0];

  assign unused_hi = ^{sumX[COORD_W+1:LX_W], sumY[COORD_W+1:LY_W]};

endmodule

// File: rtl/sprite_hit_unit.sv
// Multi-sprite hit detector: frame-shadowed sprite state, 2-stage priority pipeline.
// Per-frame collision flags are built only when SPRITE_HIT_COLLISION_EN is defined.
module sprite_hit_unit #(
  parameter int  NUM_SPRITES = 4,
  parameter int  COORD_W     = 10,
  parameter int  HALF_W      = 42,
  parameter int  HALF_H      = 46,
  localparam int ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int LX_W        = $clog2(2*HALF_W+1),
  localparam int LY_W        = $clog2(2*HALF_H+1)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  input  logic [NUM_SPRITES*COORD_W-1:0] center_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] center_y,
  output logic                           hit_valid,
  output logic                           hit,
  output logic [ID_W-1:0]                hit_id,
  output logic [LX_W-1:0]                local_x,
  output logic [LY_W-1:0]                local_y,
  output logic [NUM_SPRITES-1:0]         collision
);

  logic [NUM_SPRITES-1:0]         en_q;
  logic [NUM_SPRITES*COORD_W-1:0] cx_q;
  logic [NUM_SPRITES*COORD_W-1:0] cy_q;

  logic [NUM_SPRITES-1:0] in_c;
  logic [LX_W-1:0]        offX_c [NUM_SPRITES];
  logic [LY_W-1:0]        offY_c [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] in_q;
  logic [LX_W-1:0]        offX_q [NUM_SPRITES];
  logic [LY_W-1:0]        offY_q [NUM_SPRITES];
  logic                   valid1_q;

  logic            hit_d,   hit_q;
  logic [ID_W-1:0] id_d,    id_q;
  logic [LX_W-1:0] lx_d,    lx_q;
  logic [LY_W-1:0] ly_d,    ly_q;
  logic            hitValid_q;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_box
    sprite_box_test #(
      .COORD_W (COORD_W),
      .HALF_W  (HALF_W),
      .HALF_H  (HALF_H),
      .LX_W    (LX_W),
      .LY_W    (LY_W)
    ) u_box (
      .en_i    (en_q[i]),
      .x_i     (DrawX),
      .y_i     (DrawY),
      .cx_i    (cx_q[i*COORD_W +: COORD_W]),
      .cy_i    (cy_q[i*COORD_W +: COORD_W]),
      .in_o    (in_c[i]),
      .off_x_o (offX_c[i]),
      .off_y_o (offY_c[i])
    );
  end

  // Shadows change only at frame_start, so a pixel in stage 1 on that edge still sees the old set.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      en_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      in_q     <= '0;
      offX_q   <= '{default: '0};
      offY_q   <= '{default: '0};
      valid1_q <= 1'b0;
    end else begin
      if (frame_start) begin
        en_q <= sprite_en;
        cx_q <= center_x;
        cy_q <= center_y;
      end
      in_q     <= in_c & {NUM_SPRITES{pix_valid}};
      offX_q   <= offX_c;
      offY_q   <= offY_c;
      valid1_q <= pix_valid;
    end
  end

  // Walking from the top index down leaves the lowest-index hit as the winner.
  always_comb begin
    hit_d = |in_q;
    id_d  = '0;
    lx_d  = '0;
    ly_d  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (in_q[i]) begin
        id_d = ID_W'(i);
        lx_d = offX_q[i];
        ly_d = offY_q[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hitValid_q <= 1'b0;
      hit_q      <= 1'b0;
      id_q       <= '0;
      lx_q       <= '0;
      ly_q       <= '0;
    end else begin
      hitValid_q <= valid1_q;
      hit_q      <= hit_d;
      id_q       <= id_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
    end
  end

  assign hit_valid = hitValid_q;
  assign hit       = hit_q;
  assign hit_id    = id_q;
  assign local_x   = lx_q;
  assign local_y   = ly_q;

`ifdef SPRITE_HIT_COLLISION_EN
  logic [NUM_SPRITES-1:0] set_c;
  logic [NUM_SPRITES-1:0] sticky_q;
  logic [NUM_SPRITES-1:0] coll_q;

  always_comb begin
    set_c = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      set_c[i] = pix_valid && in_c[i] && ((in_c & ~(NUM_SPRITES'(1) << i)) != '0);
    end
  end

  // The frame_start cycle's own overlaps still belong to the frame that is closing.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sticky_q <= '0;
      coll_q   <= '0;
    end else if (frame_start) begin
      coll_q   <= sticky_q | set_c;
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_q | set_c;
    end
  end

  assign collision = coll_q;
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_sprite_hit_unit.sv
// Scoreboard bench for sprite_hit_unit: a reference model predicts each valid pixel's result,
// and a monitor pops and compares when hit_valid arrives.
module tb_sprite_hit_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  sprite_en;
  logic [39:0] center_x;
  logic [39:0] center_y;
  logic        hit_valid;
  logic        hit;
  logic [1:0]  hit_id;
  logic [6:0]  local_x;
  logic [6:0]  local_y;
  logic [3:0]  collision;

  typedef struct {
    int         due;
    logic       hit;
    logic [1:0] id;
    logic [6:0] lx;
    logic [6:0] ly;
  } exp_t;

  exp_t sbq[$];
  int   mEn[4];
  int   mCx[4];
  int   mCy[4];
  int   cycle = 0;
  int   nChecks = 0;
  int   nFails = 0;

  sprite_hit_unit dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_en   (sprite_en),
    .center_x    (center_x),
    .center_y    (center_y),
    .hit_valid   (hit_valid),
    .hit         (hit),
    .hit_id      (hit_id),
    .local_x     (local_x),
    .local_y     (local_y),
    .collision   (collision)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycle <= cycle + 1;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // First enabled box found in ascending order is the winner.
  function automatic exp_t predict(int x, int y);
    exp_t e;
    e.due = 0; e.hit = 1'b0; e.id = '0; e.lx = '0; e.ly = '0;
    for (int k = 0; k < 4; k++) begin
      if (!e.hit && mEn[k] != 0 && iabs(x - mCx[k]) <= 42 && iabs(y - mCy[k]) <= 46) begin
        e.hit = 1'b1;
        e.id  = 2'(k);
        e.lx  = 7'(x - mCx[k] + 42);
        e.ly  = 7'(y - mCy[k] + 46);
      end
    end
    return e;
  endfunction

  task automatic setSprite(input int k, input int x, input int y);
    center_x[k*10 +: 10] = 10'(x);
    center_y[k*10 +: 10] = 10'(y);
  endtask

  // Drives one cycle of stimulus; valid pixels outside reset enter the scoreboard.
  task automatic applyStimulus(input logic fs, input logic v, input int x, input int y);
    exp_t e;
    frame_start = fs;
    pix_valid   = v;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    if (v && Reset_n) begin
      e = predict(x, y);
      e.due = cycle + 2;
      sbq.push_back(e);
    end
    if (!Reset_n) begin
      for (int k = 0; k < 4; k++) begin mEn[k] = 0; mCx[k] = 0; mCy[k] = 0; end
    end else if (fs) begin
      for (int k = 0; k < 4; k++) begin
        mEn[k] = int'(sprite_en[k]);
        mCx[k] = int'(center_x[k*10 +: 10]);
        mCy[k] = int'(center_y[k*10 +: 10]);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) applyStimulus(1'b0, 1'b0, 0, 0);
    nChecks++;
    if (sbq.size() != 0) begin
      nFails++;
      $display("[TB] FAIL %s_drain: %0d pixels never produced output, expected 0 pending", name, sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard monitor: checks value and exact 2-cycle latency of every result.
  always @(negedge Clk) begin : checkOutput
    exp_t e;
    if (hit_valid === 1'b1) begin
      nChecks++;
      if (sbq.size() == 0) begin
        nFails++;
        $display("[TB] FAIL spurious_output: hit_valid=1 at cycle %0d with no pixel pending", cycle);
      end else begin
        e = sbq.pop_front();
        if (e.due !== cycle || hit !== e.hit || hit_id !== e.id || local_x !== e.lx || local_y !== e.ly) begin
          nFails++;
          $display("[TB] FAIL pixel_result: got cycle=%0d hit=%b id=%0d lx=%0d ly=%0d, expected cycle=%0d hit=%b id=%0d lx=%0d ly=%0d",
                   cycle, hit, hit_id, local_x, local_y, e.due, e.hit, e.id, e.lx, e.ly);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cycle) begin
      nChecks++;
      nFails++;
      e = sbq.pop_front();
      $display("[TB] FAIL missing_output: hit_valid=%b at cycle %0d, expected 1 (due %0d)", hit_valid, cycle, e.due);
    end
  end

  task automatic test_reset;
    Reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    nChecks++;
    if ({hit_valid, hit, hit_id, local_x, local_y, collision} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got hv=%b hit=%b id=%0d lx=%0d ly=%0d coll=%b, expected all 0",
               hit_valid, hit, hit_id, local_x, local_y, collision);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_basic_hit;
    setSprite(0, 320, 240);
    sprite_en = 4'b0001;
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 362, 286);
    applyStimulus(1'b0, 1'b1, 363, 240);
    @(negedge Clk);
    nChecks++;
    if (hit !== 1'b1 || hit_id !== 2'd0 || local_x !== 7'd84 || local_y !== 7'd92) begin
      nFails++;
      $display("[TB] FAIL corner_hit: got hit=%b id=%0d lx=%0d ly=%0d, expected hit=1 id=0 lx=84 ly=92",
               hit, hit_id, local_x, local_y);
    end
    drain("basic");
  endtask

  task automatic test_priority;
    setSprite(0, 100, 100);
    setSprite(2, 120, 100);
    sprite_en = 4'b0101;
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 110, 100);
    sprite_en = 4'b0100;
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 110, 100);
    drain("priority");
  endtask

  task automatic test_shadow;
    sprite_en = 4'b0001;
    setSprite(0, 100, 100);
    applyStimulus(1'b1, 1'b0, 0, 0);
    setSprite(0, 500, 100);
    applyStimulus(1'b0, 1'b1, 100, 100);
    applyStimulus(1'b0, 1'b1, 500, 100);
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 500, 100);
    applyStimulus(1'b0, 1'b1, 100, 100);
    setSprite(0, 100, 100);
    applyStimulus(1'b1, 1'b1, 500, 100);
    applyStimulus(1'b0, 1'b1, 500, 100);
    drain("shadow");
  endtask

  task automatic test_edge_wrap;
    setSprite(1, 0, 0);
    sprite_en = 4'b0010;
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1023, 0);
    applyStimulus(1'b0, 1'b1, 5, 5);
    applyStimulus(1'b0, 1'b0, 0, 0);
    @(negedge Clk);
    nChecks++;
    if (hit !== 1'b1 || hit_id !== 2'd1 || local_x !== 7'd47 || local_y !== 7'd51) begin
      nFails++;
      $display("[TB] FAIL wrap_hit: got hit=%b id=%0d lx=%0d ly=%0d, expected hit=1 id=1 lx=47 ly=51",
               hit, hit_id, local_x, local_y);
    end
    drain("wrap");
  endtask

  task automatic test_back_to_back;
    setSprite(0, 300, 200);
    setSprite(1, 330, 220);
    setSprite(2, 600, 400);
    setSprite(3, 1000, 20);
    sprite_en = 4'b1011;
    applyStimulus(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 2)
        applyStimulus(1'b0, $urandom_range(0, 3) != 0, 940 + $urandom_range(0, 83), $urandom_range(0, 80));
      else
        applyStimulus(1'b0, $urandom_range(0, 3) != 0, 240 + $urandom_range(0, 150), 140 + $urandom_range(0, 140));
    end
    drain("back_to_back");
  endtask

  task automatic test_collision;
    setSprite(0, 200, 200);
    setSprite(1, 210, 200);
    sprite_en = 4'b0011;
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 205, 200);
    applyStimulus(1'b0, 1'b1, 150, 200);
    applyStimulus(1'b1, 1'b0, 0, 0);
`ifdef SPRITE_HIT_COLLISION_EN
    nChecks++;
    if (collision !== 4'b0011) begin
      nFails++;
      $display("[TB] FAIL collision_set: got %b, expected 0011", collision);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 250, 200);
      applyStimulus(1'b0, 1'b0, 205, 200);
      nChecks++;
      if (collision !== 4'b0011) begin
        nFails++;
        $display("[TB] FAIL collision_hold: got %b, expected 0011", collision);
      end
    end
    applyStimulus(1'b1, 1'b0, 0, 0);
    nChecks++;
    if (collision !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL collision_clear: got %b, expected 0000", collision);
    end
`else
    nChecks++;
    if (collision !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL collision_disabled: got %b, expected 0000", collision);
    end
`endif
    drain("collision");
  endtask

  task automatic test_reset_midstream;
    setSprite(0, 400, 300);
    sprite_en = 4'b0001;
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 400, 300);
    Reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 401, 300);
    sbq.delete();
    @(negedge Clk);
    nChecks++;
    if ({hit_valid, hit, hit_id, local_x, local_y, collision} !== '0) begin
      nFails++;
      $display("[TB] FAIL midstream_reset: got hv=%b hit=%b id=%0d lx=%0d ly=%0d coll=%b, expected all 0",
               hit_valid, hit, hit_id, local_x, local_y, collision);
    end
    Reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 400, 300);
    @(negedge Clk);
    nChecks++;
    if (hit_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL release_flush: hit_valid=%b, expected 0", hit_valid);
    end
    applyStimulus(1'b0, 1'b1, 400, 300);
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 400, 300);
    drain("midstream");
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    sprite_en   = '0;
    center_x    = '0;
    center_y    = '0;
    for (int k = 0; k < 4; k++) begin mEn[k] = 0; mCx[k] = 0; mCy[k] = 0; end
    @(posedge Clk);
    #1;
    test_reset;
    test_basic_hit;
    test_priority;
    test_shadow;
    test_edge_wrap;
    test_back_to_back;
    test_collision;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
